uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 73 +++++++
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO. Occupancy-counted full/empty, RAM array with a
// registered head read so the head word is ready the cycle after any write.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] head_reg;
    logic             push_ok, pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    assign wr_ptr_next = wr_ptr_reg + AW'(push_ok);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // The only way the next head slot is being written right now is when the
    // FIFO is (or becomes) empty, so forward the incoming word in that case.
    always_ff @(posedge sys_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= push_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    assign head  = head_reg;
    assign level = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter with a 16x-oversampled baud counter
// whose divisor is latched at the start of every frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_ni,
    input  logic [DIV_W-1:0]              divisor_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o
);

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W = DIV_W + OS_W;
    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t            state_reg, state_next;
    logic                 fifo_empty, fifo_full;
    logic [7:0]           fifo_head;
    logic [LW-1:0]        fifo_level;
    logic                 push, pop;
    logic                 armed_reg;
    logic                 bit_done, last_bit;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [DIV_W-1:0]     div_m1_reg, div_m1_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg, tx_next;
    logic                 overflow_reg;

    assign push = tx_valid_i && !fifo_full;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_ni (sys_rst_ni),
        .push       (push),
        .push_data  (tx_data_i),
        .pop        (pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .level      (fifo_level)
    );

    // A bit lasts 16*div cycles: terminal count is (div-1) followed by four ones.
    assign bit_done = (cnt_reg == {div_m1_reg, {OS_W{1'b1}}});
    assign last_bit = (idx_reg == IDX_W'(DATA_BITS - 1));

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // armed_reg delays the wake-up from IDLE by one cycle so a fresh byte
    // always reaches the line on the second edge after it was accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (armed_reg && !fifo_empty) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && last_bit) state_next = STOP;
            STOP:    if (bit_done) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop         = (state_next == START) && (state_reg != START);
        div_m1_next = div_m1_reg;
        cnt_next    = '0;
        idx_next    = '0;
        shift_next  = shift_reg;
        tx_next     = 1'b1;

        if (pop) begin
            div_m1_next = (divisor_i == '0) ? '0 : divisor_i - 1'b1;
            shift_next  = fifo_head;
        end else if ((state_reg == DATA) && bit_done) begin
            shift_next = shift_reg >> 1;
        end

        if ((state_reg != IDLE) && !bit_done) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        if (state_reg == DATA) begin
            idx_next = bit_done ? idx_reg + 1'b1 : idx_reg;
        end

        // The line register follows the state being entered, not the current one.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            armed_reg    <= 1'b0;
            cnt_reg      <= '0;
            div_m1_reg   <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            armed_reg    <= !fifo_empty;
            cnt_reg      <= cnt_next;
            div_m1_reg   <= div_m1_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            overflow_reg <= tx_valid_i && fifo_full;
        end
    end

    assign uart_tx_o  = tx_reg;
    assign tx_ready_o = !fifo_full;
    assign busy_o     = (state_reg != IDLE) || !fifo_empty;
    assign level_o    = fifo_level;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/time-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] divisor;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             uart_tx;
    logic             busy;
    logic [4:0]       level;
    logic             overflow;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    byte unsigned q[$];
    bit           m_active  = 1'b0;
    int           m_el      = 0;
    int           m_d       = 1;
    int           m_sz      = 0;
    logic [7:0]   m_sh      = 8'h00;
    bit           m_prev_ne = 1'b0;
    bit           m_ne      = 1'b0;
    bit           m_ovf     = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_ni (rst_n),
        .divisor_i  (divisor),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .uart_tx_o  (uart_tx),
        .busy_o     (busy),
        .level_o    (level),
        .overflow_o (overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic start_frame();
        m_sh     = q.pop_front();
        m_d      = (divisor == 0) ? 1 : int'(divisor);
        m_el     = 0;
        m_active = 1'b1;
    endtask

    // Model: a frame is 10 bits of 16*d cycles; the next queued byte starts
    // the moment a frame ends, and an idle line starts a byte once the queue
    // has been non-empty across a full cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_active  = 1'b0;
            m_el      = 0;
            m_prev_ne = 1'b0;
            m_ovf     = 1'b0;
        end else begin
            m_sz  = q.size();
            m_ne  = (m_sz > 0);
            m_ovf = tx_valid && (m_sz == DEPTH);
            if (m_active) begin
                m_el++;
                if (m_el == 160 * m_d) begin
                    if (m_ne) start_frame();
                    else m_active = 1'b0;
                end
            end else if (m_ne && m_prev_ne) begin
                start_frame();
            end
            if (tx_valid && (m_sz < DEPTH)) q.push_back(tx_data);
            m_prev_ne = m_ne;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("line",     int'(uart_tx),
                m_active ? int'(frame_bit(m_sh, m_el / (16 * m_d))) : 1);
            chk("level",    int'(level), q.size());
            chk("busy",     int'(busy), int'(m_active || (q.size() > 0)));
            chk("ready",    int'(tx_ready), int'(q.size() < DEPTH));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic recv_byte(input int d, output int b, output int ok);
        int t;
        b  = 0;
        ok = 1;
        t  = 0;
        while (uart_tx !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            ok = 0;
            return;
        end
        tick(8 * d);
        if (uart_tx !== 1'b0) ok = 0;
        for (int i = 0; i < 8; i++) begin
            tick(16 * d);
            b[i] = uart_tx;
        end
        tick(16 * d);
        if (uart_tx !== 1'b1) ok = 0;
    endtask

    initial begin
        int rb;
        int rok;
        int lows;
        int t;
        logic [9:0] pat55;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        divisor  = 16'd1;
        tick(3);
        chk_en = 1'b1;
        chk("rst_line", int'(uart_tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        tick(2);

        // 0x55 at divisor 1: start, data LSB first, stop
        pat55 = 10'b1010101010;
        @(negedge clk); tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk); chk("t1_lat1", int'(uart_tx), 1);
        @(negedge clk); chk("t1_start", int'(uart_tx), 0);
        for (int k = 0; k < 10; k++) begin
            tick((k == 0) ? 8 : 16);
            chk($sformatf("t1_bit%0d", k), int'(uart_tx), int'(pat55[k]));
        end
        tick(7);  chk("t1_busy159", int'(busy), 1);
        tick(1);  chk("t1_busy160", int'(busy), 0);
        tick(3);

        // three back-to-back frames at divisor 2
        @(negedge clk); divisor = 16'd2; tx_data = 8'h01; tx_valid = 1'b1;
        @(negedge clk); chk("t2_lvl1", int'(level), 1); tx_data = 8'h02;
        @(negedge clk); chk("t2_lvl2", int'(level), 2); tx_data = 8'h03;
        @(negedge clk); chk("t2_lvl3", int'(level), 2); tx_valid = 1'b0;
        chk("t2_start", int'(uart_tx), 0);
        tick(319); chk("t2_lvl_319", int'(level), 2);
        tick(1);   chk("t2_lvl_320", int'(level), 1);
        chk("t2_start2", int'(uart_tx), 0);
        tick(639); chk("t2_busy959", int'(busy), 1);
        tick(1);   chk("t2_busy960", int'(busy), 0);
        tick(3);

        // fill while stalled, then overflow
        divisor = 16'd1000;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk); tx_data = 8'($urandom); tx_valid = 1'b1;
        end
        @(negedge clk);
        chk("t3_full_lvl", int'(level), 16);
        chk("t3_ready", int'(tx_ready), 0);
        tx_data = 8'hEE;
        @(negedge clk); tx_valid = 1'b0;
        chk("t3_ovf_hi", int'(overflow), 1);
        chk("t3_lvl_keep", int'(level), 16);
        @(negedge clk); chk("t3_ovf_lo", int'(overflow), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t3_rst_line", int'(uart_tx), 1);
        chk("t3_rst_lvl", int'(level), 0);
        rst_n = 1'b1;
        tick(2);

        // reset in the middle of a frame
        divisor = 16'd1;
        @(negedge clk); tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        tick(2);
        tick(16 * 5 + 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_line", int'(uart_tx), 1);
        chk("t4_lvl", int'(level), 0);
        chk("t4_busy", int'(busy), 0);
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("t4_quiet", lows, 0);

        // serial decode of two frames at divisor 43
        divisor = 16'd43;
        @(negedge clk); tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk); tx_data = 8'h00;
        @(negedge clk); tx_valid = 1'b0;
        recv_byte(43, rb, rok);
        chk("t5_ok0", rok, 1);
        chk("t5_byte0", rb, 32'hA5);
        recv_byte(43, rb, rok);
        chk("t5_ok1", rok, 1);
        chk("t5_byte1", rb, 32'h00);
        tick(8 * 43 + 4);

        // divisor change mid-frame only affects the next frame
        divisor = 16'd1;
        @(negedge clk); tx_data = 8'h0F; tx_valid = 1'b1;
        @(negedge clk); tx_data = 8'hF0;
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk); chk("t6_start", int'(uart_tx), 0);
        tick(40); divisor = 16'd3;
        tick(39); chk("t6_b79", int'(uart_tx), 1);
        tick(1);  chk("t6_b80", int'(uart_tx), 0);
        tick(80); chk("t6_f2_start", int'(uart_tx), 0);
        tick(239); chk("t6_f2_399", int'(uart_tx), 0);
        tick(1);   chk("t6_f2_400", int'(uart_tx), 1);
        tick(239); chk("t6_busy639", int'(busy), 1);
        tick(1);   chk("t6_busy640", int'(busy), 0);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n    = ($urandom_range(0, 1499) != 0);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 199) == 0) divisor = DIV_W'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        t = 0;
        while ((m_active || q.size() > 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", int'(t < 20000), 1);
        tick(2);
        chk("drain_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
